// File: rtl/get_ins_multi.sv
// get_ins_multi: per-layer instruction fetch front end for DLA64.
// Each layer begins with NUM_INS configuration words, which are captured into instr_code.
// After the last of them, start_reg pulses for one cycle. The payload that follows is then
// passed straight through to the downstream reader until a word with TLAST is consumed.
// The block then re-arms for the next layer by itself and counts how many layers it has started.
module get_ins_multi #(
    parameter int TBITS   = 64,
    parameter int TBYTE   = 8,
    parameter int NUM_INS = 3,
    parameter int LCNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [TBITS-1:0]         fifo_data_din,
    input  logic [TBYTE-1:0]         fifo_strb_din,
    input  logic                     fifo_last_din,
    input  logic                     fifo_empty_n_din,
    output logic                     fifo_read_dout,
    output logic [TBITS-1:0]         ds_data,
    output logic [TBYTE-1:0]         ds_strb,
    output logic                     ds_last,
    output logic                     ds_empty_n,
    input  logic                     ds_read,
    output logic [NUM_INS*TBITS-1:0] instr_code,
    output logic                     instr_valid,
    output logic                     start_reg,
    output logic                     layer_done,
    output logic                     err_short,
    output logic [LCNT_W-1:0]        layer_cnt
);

    localparam int IDX_W = (NUM_INS > 1) ? $clog2(NUM_INS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_STREAM = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t                   state_r;
    state_t                   state_nxt_s;
    logic [IDX_W-1:0]         idx_r;
    logic [NUM_INS*TBITS-1:0] instr_code_r;
    logic                     instr_valid_r;
    logic                     start_reg_r;
    logic                     layer_done_r;
    logic                     err_short_r;
    logic [LCNT_W-1:0]        layer_cnt_r;

    logic                     load_enter_s;   // IDLE -> LOAD transition this cycle
    logic                     load_acc_s;     // instruction word accepted this cycle
    logic                     load_final_s;   // accepted word completes the instruction set
    logic                     load_short_s;   // TLAST arrived before the set was complete
    logic                     stream_acc_s;   // payload word handed to downstream this cycle
    logic                     pop_s;

    // Next-state decode and the pop/acceptance strobes for each state
    always_comb begin
        state_nxt_s  = state_r;
        load_enter_s = 1'b0;
        load_acc_s   = 1'b0;
        load_final_s = 1'b0;
        load_short_s = 1'b0;
        stream_acc_s = 1'b0;
        pop_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fifo_empty_n_din) begin
                    state_nxt_s  = ST_LOAD;
                    load_enter_s = 1'b1;
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_LOAD: begin
                pop_s = fifo_empty_n_din;
                if (fifo_empty_n_din) begin
                    load_acc_s = 1'b1;
                    if (idx_r == LAST_IDX) begin
                        // TLAST on the final instruction word is a normal capture
                        load_final_s = 1'b1;
                        state_nxt_s  = ST_START;
                    end else if (fifo_last_din) begin
                        load_short_s = 1'b1;
                        state_nxt_s  = ST_IDLE;
                    end else begin
                        state_nxt_s  = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_START: begin
                state_nxt_s = ST_STREAM;
            end
            ST_STREAM: begin
                stream_acc_s = ds_read & fifo_empty_n_din;
                pop_s        = stream_acc_s;
                if (stream_acc_s && fifo_last_din) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_STREAM;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Zero-latency payload pass-through, forced to zero outside STREAM
    always_comb begin
        ds_data    = {TBITS{1'b0}};
        ds_strb    = {TBYTE{1'b0}};
        ds_last    = 1'b0;
        ds_empty_n = 1'b0;
        if (state_r == ST_STREAM) begin
            ds_data    = fifo_data_din;
            ds_strb    = fifo_strb_din;
            ds_last    = fifo_last_din;
            ds_empty_n = fifo_empty_n_din;
        end else begin
            ds_data    = {TBITS{1'b0}};
            ds_strb    = {TBYTE{1'b0}};
            ds_last    = 1'b0;
            ds_empty_n = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Instruction index: cleared on LOAD entry, advances on each non-final accepted word
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_r <= {IDX_W{1'b0}};
        end else if (load_enter_s) begin
            idx_r <= {IDX_W{1'b0}};
        end else if (load_acc_s && !load_final_s && !load_short_s) begin
            idx_r <= idx_r + IDX_W'(1);
        end else begin
            idx_r <= idx_r;
        end
    end

    // Instruction capture: the accepted word goes into the slot selected by idx_r
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_code_r <= {(NUM_INS*TBITS){1'b0}};
        end else begin
            for (int k = 0; k < NUM_INS; k++) begin
                if (load_acc_s && (idx_r == IDX_W'(k))) begin
                    instr_code_r[k*TBITS +: TBITS] <= fifo_data_din;
                end
            end
        end
    end

    // instr_valid drops on LOAD entry and rises once the set is committed in START
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_valid_r <= 1'b0;
        end else if (load_enter_s) begin
            instr_valid_r <= 1'b0;
        end else if (state_r == ST_START) begin
            instr_valid_r <= 1'b1;
        end else begin
            instr_valid_r <= instr_valid_r;
        end
    end

    // Layer counter: one increment per START, wrapping naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            layer_cnt_r <= {LCNT_W{1'b0}};
        end else if (state_r == ST_START) begin
            layer_cnt_r <= layer_cnt_r + LCNT_W'(1);
        end else begin
            layer_cnt_r <= layer_cnt_r;
        end
    end

    // Registered one-cycle pulses: start/done coincide with their states, err follows the bad word
    always_ff @(posedge clk) begin
        if (reset) begin
            start_reg_r  <= 1'b0;
            layer_done_r <= 1'b0;
            err_short_r  <= 1'b0;
        end else begin
            start_reg_r  <= (state_nxt_s == ST_START);
            layer_done_r <= (state_nxt_s == ST_DONE);
            err_short_r  <= load_short_s;
        end
    end

    assign fifo_read_dout = pop_s;
    assign instr_code     = instr_code_r;
    assign instr_valid    = instr_valid_r;
    assign start_reg      = start_reg_r;
    assign layer_done     = layer_done_r;
    assign err_short      = err_short_r;
    assign layer_cnt      = layer_cnt_r;

endmodule
